// File: rtl/seq_div_12bit_if.sv
// Start/ready handshake bundle between the execute stage and the
// sequential divider.
`timescale 1ns/1ps
interface seq_div_12bit_if #(
  parameter int WIDTH = 12
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             ready;
  logic             busy;
  logic             div_by_zero;

  // Requester side: issues operands, consumes results.
  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, ready, busy, div_by_zero
  );

  // Divider side.
  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, ready, busy, div_by_zero
  );
endinterface

// File: rtl/seq_div_12bit.sv
// Restoring unsigned divider: one quotient bit per clock by trial
// subtraction (A + ~B + 1, carry-out 1 = no borrow). Divide-by-zero
// skips the iterations and is flagged with a saturated quotient.
`timescale 1ns/1ps
module seq_div_12bit #(
  parameter int WIDTH = 12
) (
  input  logic          clock,
  input  logic          reset,
  seq_div_12bit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH:0]   r_q, r_d;           // partial remainder
  logic [WIDTH-1:0] q_q, q_d;           // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] d_q, d_d;           // latched divisor
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   s;
  logic [WIDTH+1:0] t;
  logic             no_borrow;
  logic [WIDTH:0]   r_step;
  logic [WIDTH-1:0] q_step;

  // One trial subtraction: shift next dividend bit into R, subtract D.
  always_comb begin
    s         = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    t         = {1'b0, s} + {1'b0, ~{1'b0, d_q}} + {{(WIDTH+1){1'b0}}, 1'b1};
    // A set bit shifted out of R would make S exceed D as well, so it
    // also counts as no borrow (it stays 0 while R < D holds).
    no_borrow = t[WIDTH+1] | r_q[WIDTH];
    r_step    = no_borrow ? t[WIDTH:0] : s;
    q_step    = {q_q[WIDTH-2:0], no_borrow};
  end

  // Next-state, datapath load and registered-output decode.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path through
    // the case statement leaves one unassigned (which would infer a latch).
    state_d     = state_q;
    r_d         = r_q;
    q_d         = q_q;
    d_d         = d_q;
    count_d     = count_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          if (bus.divisor != '0) begin
            d_d     = bus.divisor;
            q_d     = bus.dividend;
            r_d     = '0;
            count_d = '0;
            dbz_d   = 1'b0;
            state_d = RUN;
          end else begin
            quotient_d  = '1;
            remainder_d = bus.dividend;
            dbz_d       = 1'b1;
            state_d     = DONE;
          end
        end
      end
      RUN: begin
        r_d     = r_step;
        q_d     = q_step;
        count_d = count_q + 1'b1;
        if (count_q == CW'(WIDTH - 1)) begin
          quotient_d  = q_step;
          remainder_d = r_step[WIDTH-1:0];
          state_d     = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d == RUN);
    ready_d = (state_d == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q     <= IDLE;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      count_q     <= count_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.ready       = ready_q;
  assign bus.busy        = busy_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_div_12bit.sv
// Bench for seq_div_12bit: directed vectors plus a random sweep; expected
// results are queued at issue time and compared by a monitor on ready.
`timescale 1ns/1ps
module tb_seq_div_12bit;
  localparam int WIDTH = 12;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  seq_div_12bit_if #(.WIDTH(WIDTH)) bus ();

  seq_div_12bit #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] div;
    logic             dbz;
  } exp_t;

  exp_t             sb[$];
  int               checks = 0;
  int               errors = 0;
  bit               have_last = 1'b0;
  logic [WIDTH-1:0] last_q, last_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each presented result against the oldest expectation,
  // and require results to hold steady between ready pulses.
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (bus.ready) begin
        if (sb.size() == 0) begin
          check("unexpected_ready", 32'(bus.ready), 0);
        end else begin
          e = sb.pop_front();
          check("quotient", 32'(bus.quotient), 32'(e.quo));
          check("remainder", 32'(bus.remainder), 32'(e.rem));
          check("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
          if (!e.dbz) check("rem_lt_div", 32'(bus.remainder < e.div), 1);
        end
        last_q    = bus.quotient;
        last_r    = bus.remainder;
        have_last = 1'b1;
      end else if (have_last) begin
        check("hold_quotient", 32'(bus.quotient), 32'(last_q));
        check("hold_remainder", 32'(bus.remainder), 32'(last_r));
      end
    end
  end

  // Issue one operation at the current negedge and wait (bounded) for ready.
  // intrude pulses a second start with 50/5 five cycles in.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                        input bit intrude);
    exp_t e;
    int   lat    = 0;
    int   busy_n = 0;
    e.quo = eq;
    e.rem = er;
    e.div = b;
    e.dbz = (b == '0);
    sb.push_back(e);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    do begin
      @(negedge clock);
      lat++;
      bus.start = 1'b0;
      if (intrude && lat == 5) begin
        bus.start    = 1'b1;
        bus.dividend = 12'd50;
        bus.divisor  = 12'd5;
      end else begin
        // Operand changes while running must not disturb the result.
        bus.dividend = WIDTH'($urandom);
        bus.divisor  = WIDTH'($urandom);
      end
      if (bus.busy) busy_n++;
    end while (!bus.ready && lat < 40);
    bus.start = 1'b0;
    if (b != '0) begin
      // lat counts negedges from start; the first is right after the accepting edge.
      check("latency_after_accept", lat - 1, WIDTH);
      check("busy_cycles", busy_n, WIDTH);
    end else begin
      check("dbz_latency", lat, 1);
      check("dbz_busy_cycles", busy_n, 0);
    end
  endtask

  initial begin
    int ready_seen;
    logic [WIDTH-1:0] a, b;

    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(negedge clock);
    check("rst_quotient", 32'(bus.quotient), 0);
    check("rst_remainder", 32'(bus.remainder), 0);
    check("rst_ready", 32'(bus.ready), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_dbz", 32'(bus.div_by_zero), 0);
    reset = 1'b0;
    @(negedge clock);

    // Basic and extremes, separated by idle cycles.
    run_op(12'd100, 12'd7, 12'd14, 12'd2, 1'b0);
    repeat (2) @(negedge clock);
    run_op(12'd4095, 12'd1, 12'd4095, 12'd0, 1'b0);
    @(negedge clock);
    run_op(12'd5, 12'd9, 12'd0, 12'd5, 1'b0);
    @(negedge clock);
    run_op(12'd4095, 12'd4095, 12'd1, 12'd0, 1'b0);
    @(negedge clock);
    run_op(12'd2048, 12'd3, 12'd682, 12'd2, 1'b0);
    @(negedge clock);

    // Divide-by-zero, then a normal op that must clear the flag.
    run_op(12'd1234, 12'd0, 12'd4095, 12'd1234, 1'b0);
    @(negedge clock);

    // Start during RUN ignored; back-to-back start from DONE accepted.
    run_op(12'd100, 12'd7, 12'd14, 12'd2, 1'b1);
    run_op(12'd50, 12'd5, 12'd10, 12'd0, 1'b0);
    @(negedge clock);

    // Reset at cycle 6 of 100/7 aborts with no ready and zeroed outputs.
    bus.start    = 1'b1;
    bus.dividend = 12'd100;
    bus.divisor  = 12'd7;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (5) @(negedge clock);
    reset     = 1'b1;
    have_last = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    check("abort_quotient", 32'(bus.quotient), 0);
    check("abort_remainder", 32'(bus.remainder), 0);
    check("abort_ready", 32'(bus.ready), 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_dbz", 32'(bus.div_by_zero), 0);
    ready_seen = 0;
    repeat (15) begin
      @(negedge clock);
      if (bus.ready) ready_seen++;
    end
    check("abort_no_ready", ready_seen, 0);
    run_op(12'd9, 12'd2, 12'd4, 12'd1, 1'b0);
    @(negedge clock);

    // Random sweep, mostly back-to-back, some small divisors.
    for (int i = 0; i < 1000; i++) begin
      a = WIDTH'($urandom_range(0, 4095));
      b = (i % 4 == 0) ? WIDTH'($urandom_range(1, 15)) : WIDTH'($urandom_range(1, 4095));
      run_op(a, b, a / b, a % b, 1'b0);
      if (i % 8 == 7) @(negedge clock);
    end

    // Divide-by-zero accepted straight out of DONE.
    run_op(12'd7, 12'd0, 12'd4095, 12'd7, 1'b0);

    repeat (3) @(negedge clock);
    check("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_div_12bit.md
# seq_div_12bit

Multi-cycle unsigned 12-bit divider that produces one quotient bit per clock using repeated trial subtraction. The trial subtraction is the adder run in reverse: dividend-side minus divisor, computed as A + ~B with carry-in 1. A carry-out of 1 means no borrow. The block sits beside the ALU in the execute stage and is driven by a start/ready handshake. Divide-by-zero is flagged as an exception rather than computed.

## Interface
- WIDTH, 12, operand, quotient and remainder width; the iteration count equals WIDTH
- clock  input  1  rising-edge clock for all state
- reset  input  1  synchronous, active-high; clears all state and outputs
- start  input  1  request; sampled only in IDLE or DONE
- dividend  input  WIDTH  unsigned numerator; sampled on the accepting edge
- divisor  input  WIDTH  unsigned denominator; sampled on the accepting edge
- quotient  output  WIDTH  registered result; held until the next accepted start
- remainder  output  WIDTH  registered result; held until the next accepted start
- ready  output  1  one-cycle pulse; results valid
- busy  output  1  high while in RUN
- div_by_zero  output  1  exception flag for the current result; held with the results

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1 and divisor!=0:
  - latch D=divisor, Q=dividend, R=0 (WIDTH+1 bits), count=0
  - go to RUN
  - clear div_by_zero
- IDLE/DONE with start=1 and divisor==0:
  - go to DONE directly
  - quotient = all ones (4095)
  - remainder = dividend
  - div_by_zero = 1
- RUN, one iteration per edge:
  - S = {R[WIDTH-1:0], Q[WIDTH-1]}
  - T = S + ~{0,D} + 1
  - carry-out 1 (no borrow): R=T, Q={Q[WIDTH-2:0],1}
  - carry-out 0: R=S, Q={Q[WIDTH-2:0],0}
  - count increments
- RUN with count==WIDTH-1: perform the last iteration, load quotient=Q and remainder=R[WIDTH-1:0] from the final values, go to DONE.
- DONE: ready=1 for this cycle. Next edge goes to IDLE, or back to RUN/DONE if start=1 (back-to-back accepted).
- start in RUN is ignored, with no queueing. Operand changes during RUN have no effect.
- Invariant for every non-zero divisor: dividend = quotient*divisor + remainder, with remainder < divisor.
- Reset values: state IDLE; quotient=0, remainder=0, ready=0, busy=0, div_by_zero=0; internal R, Q, D, count=0.
- Reset mid-RUN or in DONE aborts. The partial result is discarded, no ready is issued, and outputs return to 0 on that edge.
- Reset and start on the same edge: reset wins.

## Timing
- Start accepted at edge k with divisor!=0:
  - busy high from after edge k through after edge k+WIDTH-1
  - results and ready visible after edge k+WIDTH (12 cycles)
  - ready drops after edge k+WIDTH+1 unless a new start re-enters DONE
- Divide-by-zero accepted at edge k: ready and results visible after edge k+1 (1 cycle); busy stays 0.
- Back-to-back: start during the DONE cycle is accepted at that edge. The next result is ready WIDTH cycles later.
- All outputs are registered; no combinational path from inputs to outputs.
- The carry chain, a WIDTH+1-bit add, is the critical path and must close in one cycle.

## Test plan
- Basic: start with dividend=100, divisor=7 -> ready exactly 12 cycles after the accepting edge; quotient=14, remainder=2, div_by_zero=0; busy high for 12 cycles.
- Extremes:
  - 4095/1 -> quotient=4095, remainder=0
  - 5/9 -> quotient=0, remainder=5
  - 4095/4095 -> quotient=1, remainder=0
  - 2048/3 -> quotient=682, remainder=2
- Divide-by-zero: dividend=1234, divisor=0 -> ready after 1 cycle; quotient=4095, remainder=1234, div_by_zero=1, busy never high.
- Busy protection:
  - during 100/7, pulse start with 50/5 at cycle 5 -> ignored; result still 14 r 2
  - then start 50/5 in the DONE cycle -> 10 r 0 ready 12 cycles later with no IDLE gap
- Reset mid-operation:
  - assert reset at cycle 6 of 100/7 -> no ready pulse; outputs all 0 the following cycle
  - a new 9/2 afterwards -> 4 r 1 in 12 cycles
- Random: 1000 random unsigned pairs with non-zero divisor, scoreboard checks quotient and remainder against reference division and remainder<divisor; results held stable between ready pulses.
